// File: rtl/adder_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   SUM_W       width of the zero-extended a+b sum
//   DIGIT_W     width of one BCD digit
//   SUM_MAX     largest possible sum of two 4-bit operands
//   bcd_digit_t one BCD digit
package adder_bcd_pkg;

   localparam int SUM_W   = 5;
   localparam int DIGIT_W = 4;
   localparam int SUM_MAX = 30;

   typedef logic [3:0] bcd_digit_t;

endpackage : adder_bcd_pkg

// File: rtl/bin5_to_bcd.sv
// Converts a 5-bit binary value (0..30) into tens and units BCD digits.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
//
// Ports:
//   bin    5-bit binary input, valid range 0..SUM_MAX
//   tens   tens digit, 0..3
//   units  units digit, 0..9
module bin5_to_bcd
   import adder_bcd_pkg::*;
(
   input  logic [SUM_W-1:0] bin,
   output bcd_digit_t       tens,
   output bcd_digit_t       units
);

   // Compare/subtract ladder. The remainder after removing whole tens
   // is always below 10, so it fits in the 4-bit units digit and the
   // truncating casts drop only zero bits.
   always_comb begin
      tens  = 4'd0;
      units = 4'(bin);
      if (bin >= 5'd30) begin
         tens  = 4'd3;
         units = 4'(bin - 5'd30);
      end else if (bin >= 5'd20) begin
         tens  = 4'd2;
         units = 4'(bin - 5'd20);
      end else if (bin >= 5'd10) begin
         tens  = 4'd1;
         units = 4'(bin - 5'd10);
      end
   end

endmodule : bin5_to_bcd

// File: rtl/adder_bcd.sv
// Adds two 4-bit unsigned operands and registers the sum as two BCD digits.
// Latency: 1 cycle from the sampling edge (in_valid high) to out_valid.
// Backpressure: none; accepts one operand pair per cycle unconditionally.
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   a, b          unsigned binary operands, 0..15
//   in_valid      sample a/b on this edge
//   bcd1, bcd2    registered units / tens digits of a+b
//   out_valid     one-cycle pulse when bcd1/bcd2 take a new result
module adder_bcd
   import adder_bcd_pkg::*;
#(
   parameter int W_IN    = 4,   // only 4 is supported
   parameter int DIGIT_W = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [W_IN-1:0]    a,
   input  logic [W_IN-1:0]    b,
   input  logic               in_valid,
   output logic [DIGIT_W-1:0] bcd1,
   output logic [DIGIT_W-1:0] bcd2,
   output logic               out_valid
);

   logic [SUM_W-1:0] sum;
   bcd_digit_t       tens;
   bcd_digit_t       units;

   // Zero-extend before adding so the carry out of bit 3 is kept.
   assign sum = SUM_W'(a) + SUM_W'(b);

   bin5_to_bcd u_bin5_to_bcd (
      .bin   (sum),
      .tens  (tens),
      .units (units)
   );

   // Digits load only on a valid sample, so X on a/b while idle never
   // reaches the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd1      <= '0;
         bcd2      <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            bcd1 <= DIGIT_W'(units);
            bcd2 <= DIGIT_W'(tens);
         end
      end
   end

endmodule : adder_bcd

// File: tb/tb_adder_bcd.sv
// Directed self-checking bench for adder_bcd.
// Latency: expects results one clk edge after the sampling edge.
// Backpressure: none exercised; the DUT has no ready path.
module tb_adder_bcd;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       in_valid;
   logic [3:0] bcd1;
   logic [3:0] bcd2;
   logic       out_valid;

   int n_checks = 0;
   int n_errors = 0;

   adder_bcd #(.W_IN(4), .DIGIT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .bcd1      (bcd1),
      .bcd2      (bcd2),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input int tens, input int units, input logic vld);
      check({tag, ".bcd2"}, 8'(bcd2), 8'(tens));
      check({tag, ".bcd1"}, 8'(bcd1), 8'(units));
      check({tag, ".vld"},  8'(out_valid), 8'(vld));
   endtask

   // Hand-computed edge vectors: a, b, tens, units
   int edge_a [5] = '{0, 9, 5, 10, 15};
   int edge_b [5] = '{0, 0, 5,  9,  5};
   int edge_t [5] = '{0, 0, 1,  1,  2};
   int edge_u [5] = '{0, 9, 0,  9,  0};

   // Bubble pattern
   logic bub_v [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   int   bub_a [5] = '{7, 2, 14, 3, 12};
   int   bub_b [5] = '{6, 1, 13, 4, 12};
   int   bub_t [5] = '{1, 1,  2, 0,  0};  // digits expected after each edge
   int   bub_u [5] = '{3, 3,  7, 7,  7};

   initial begin
      int pa, pb, sm;
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = 4'd0;
      b        = 4'd0;

      // Asynchronous reset takes effect before any clock edge.
      #2;
      check_out("reset", 0, 0, 1'b0);

      // Release reset with in_valid already high: first edge samples.
      @(negedge clk);
      rst = 1'b0; a = 4'd11; b = 4'd9; in_valid = 1'b1;
      @(negedge clk);
      check_out("11+9", 2, 0, 1'b1);

      a = 4'd15; b = 4'd15;
      @(negedge clk);
      check_out("15+15", 3, 0, 1'b1);

      // Mid-cycle reset clears outputs without an edge.
      #2 rst = 1'b1;
      #1 check_out("async_rst", 0, 0, 1'b0);
      @(negedge clk);
      check_out("rst_hold", 0, 0, 1'b0);

      rst = 1'b0; a = 4'd8; b = 4'd9; in_valid = 1'b1;
      @(negedge clk);
      check_out("8+9", 1, 7, 1'b1);
      in_valid = 1'b0; a = 4'd3; b = 4'd3;
      @(negedge clk);
      check_out("hold", 1, 7, 1'b0);

      // X on operands while idle must not disturb the outputs.
      a = 4'bxxxx; b = 4'bxxxx;
      @(negedge clk);
      check_out("x_idle", 1, 7, 1'b0);

      for (int i = 0; i < 5; i++) begin
         a = 4'(edge_a[i]); b = 4'(edge_b[i]); in_valid = 1'b1;
         @(negedge clk);
         check_out($sformatf("edge%0d", i), edge_t[i], edge_u[i], 1'b1);
      end

      // Exhaustive back-to-back: each pair checked one edge after it is driven.
      in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pa = i / 16; pb = i % 16;
         a = 4'(pa); b = 4'(pb);
         @(negedge clk);
         sm = pa + pb;
         check_out($sformatf("exh_%0d_%0d", pa, pb), sm / 10, sm % 10, 1'b1);
         check($sformatf("exh_%0d_%0d.sum", pa, pb), 8'(10 * int'(bcd2) + int'(bcd1)), 8'(sm));
         check($sformatf("exh_%0d_%0d.rng", pa, pb), 8'((bcd1 <= 4'd9) && (bcd2 <= 4'd3)), 8'd1);
      end

      // Bubble pattern: out_valid follows in_valid one edge later,
      // digits move only on valid samples (last exhaustive result is 3/0).
      for (int i = 0; i < 5; i++) begin
         a = 4'(bub_a[i]); b = 4'(bub_b[i]); in_valid = bub_v[i];
         @(negedge clk);
         check_out($sformatf("bubble%0d", i), bub_t[i], bub_u[i], bub_v[i]);
      end

      in_valid = 1'b0;
      @(negedge clk);
      check_out("idle_end", 0, 7, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule : tb_adder_bcd
